// File: rtl/seg_display_scheduler_if.sv
// rtl/seg_display_scheduler_if.sv - debug sources in, display pins out
interface seg_display_scheduler_if;
    logic [31:0] src0_value;
    logic [31:0] src1_value;
    logic [31:0] src2_value;
    logic [2:0]  src_valid;
    logic [1:0]  mode;
    logic        freeze;
    logic [7:0]  SEG_X;
    logic [7:0]  SEG_Y;
    logic [3:0]  selectX;
    logic [3:0]  selectY;
    logic [1:0]  active_src;
    logic        tick;

    modport master (
        output src0_value, src1_value, src2_value, src_valid, mode, freeze,
        input  SEG_X, SEG_Y, selectX, selectY, active_src, tick
    );

    modport slave (
        input  src0_value, src1_value, src2_value, src_valid, mode, freeze,
        output SEG_X, SEG_Y, selectX, selectY, active_src, tick
    );
endinterface

// File: rtl/seg_display_scheduler.sv
// rtl/seg_display_scheduler.sv - time-shared 2x4-digit 7-segment debug display scanner
module seg_display_scheduler #(
    parameter int SCAN_DIV    = 1024,
    parameter int HOLD_ROUNDS = 256
) (
    input logic                    clock,
    input logic                    reset,
    seg_display_scheduler_if.slave dbg
);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int HW = $clog2(HOLD_ROUNDS + 1);

    typedef enum logic [2:0] {
        BLANK0, DRV0, BLANK1, DRV1, BLANK2, DRV2, BLANK3, DRV3
    } phase_t;

    phase_t        phase, phase_next;
    logic [PW-1:0] prescaler;
    logic [HW-1:0] hold, hold_next;
    logic [1:0]    active_src, src_next, rot_src, succ1, succ2;
    logic [31:0]   shadow, next_value;
    logic          dash, was_auto;
    logic [7:0]    seg_x, seg_y;
    logic [3:0]    sel, nib_x, nib_y;
    logic          advance, boundary;

    function automatic logic [7:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 8'hFC;  4'h1: hex7 = 8'h60;  4'h2: hex7 = 8'hDA;  4'h3: hex7 = 8'hF2;
            4'h4: hex7 = 8'h66;  4'h5: hex7 = 8'hB6;  4'h6: hex7 = 8'hBE;  4'h7: hex7 = 8'hE0;
            4'h8: hex7 = 8'hFE;  4'h9: hex7 = 8'hF6;  4'hA: hex7 = 8'hEE;  4'hB: hex7 = 8'h3E;
            4'hC: hex7 = 8'h1A;  4'hD: hex7 = 8'h7A;  4'hE: hex7 = 8'h9E;  default: hex7 = 8'h8E;
        endcase
    endfunction

    assign advance = (prescaler == PW'(SCAN_DIV - 1));

    always_ff @(posedge clock) begin
        if (reset) phase <= BLANK0;
        else       phase <= phase_next;
    end

    // Odd phases drive a digit; the 3-bit increment wraps DRV3 back to BLANK0.
    always_comb begin
        phase_next = phase;
        sel        = 4'b1111;
        boundary   = 1'b0;
        if (advance) phase_next = phase_t'(phase + 3'd1);
        if (phase[0]) sel = ~(4'b0001 << phase[2:1]);
        if (advance && phase == DRV3) boundary = 1'b1;
    end

    // Source selection for the upcoming round; fixed mode overrides any hold expiry.
    always_comb begin
        succ1     = (active_src == 2'd2) ? 2'd0 : active_src + 2'd1;
        succ2     = (active_src == 2'd0) ? 2'd2 : active_src - 2'd1;
        rot_src   = active_src;
        src_next  = active_src;
        hold_next = hold;
        if (dbg.src_valid[succ1])      rot_src = succ1;
        else if (dbg.src_valid[succ2]) rot_src = succ2;
        if (dbg.mode != 2'b00) begin
            src_next  = dbg.mode - 2'd1;
            hold_next = '0;
        end else if (!was_auto) begin
            hold_next = '0;
        end else if (hold + HW'(1) == HW'(HOLD_ROUNDS)) begin
            hold_next = '0;
            src_next  = rot_src;
        end else begin
            hold_next = hold + HW'(1);
        end
        case (src_next)
            2'd0:    next_value = dbg.src0_value;
            2'd1:    next_value = dbg.src1_value;
            default: next_value = dbg.src2_value;
        endcase
    end

    always_comb begin
        case (phase[2:1])
            2'd0:    begin nib_x = shadow[31:28]; nib_y = shadow[15:12]; end
            2'd1:    begin nib_x = shadow[27:24]; nib_y = shadow[11:8];  end
            2'd2:    begin nib_x = shadow[23:20]; nib_y = shadow[7:4];   end
            default: begin nib_x = shadow[19:16]; nib_y = shadow[3:0];   end
        endcase
    end

    // Segments reload only while blanked, so a lit digit never sees them change.
    always_ff @(posedge clock) begin
        if (reset) begin
            prescaler  <= '0;
            hold       <= '0;
            active_src <= 2'd0;
            shadow     <= 32'd0;
            dash       <= 1'b0;
            was_auto   <= 1'b1;
            seg_x      <= 8'h00;
            seg_y      <= 8'h00;
        end else begin
            prescaler <= advance ? '0 : prescaler + PW'(1);
            if (boundary) begin
                active_src <= src_next;
                hold       <= hold_next;
                was_auto   <= (dbg.mode == 2'b00);
                if (!dbg.freeze) begin
                    shadow <= next_value;
                    dash   <= !dbg.src_valid[src_next];
                end
            end
            if (!phase[0]) begin
                seg_x <= dash ? 8'h02 : hex7(nib_x);
                seg_y <= dash ? 8'h02 : hex7(nib_y);
            end
        end
    end

    assign dbg.SEG_X      = seg_x;
    assign dbg.SEG_Y      = seg_y;
    assign dbg.selectX    = sel;
    assign dbg.selectY    = sel;
    assign dbg.active_src = active_src;
    assign dbg.tick       = boundary & ~reset;
endmodule

// File: tb/tb_seg_display_scheduler.sv
// tb/tb_seg_display_scheduler.sv - self-checking bench for seg_display_scheduler
module tb_seg_display_scheduler;
    localparam int SD = 2;
    localparam int HR = 2;
    localparam int RL = 8 * SD;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic reset_b = 1'b1;
    always #5 clock = ~clock;

    seg_display_scheduler_if ifa ();
    seg_display_scheduler_if ifb ();

    seg_display_scheduler #(.SCAN_DIV(SD), .HOLD_ROUNDS(HR)) dut_a (
        .clock(clock), .reset(reset), .dbg(ifa)
    );
    seg_display_scheduler #(.SCAN_DIV(1), .HOLD_ROUNDS(2)) dut_b (
        .clock(clock), .reset(reset_b), .dbg(ifb)
    );

    int n_err = 0;
    int n_checks = 0;
    logic check_on = 1'b0;

    logic [7:0] hex_tab [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                 8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h1A, 8'h7A, 8'h9E, 8'h8E};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: time since reset decides the phase; the round rules decide source and content.
    int          m_t, m_src, m_hold;
    bit          m_prev_auto, m_dash, found;
    logic [31:0] m_shadow;

    always @(posedge clock) begin
        if (reset) begin
            m_t = 0; m_src = 0; m_hold = 0; m_prev_auto = 1; m_shadow = 0; m_dash = 0;
        end else begin
            if (m_t % RL == RL - 1) begin
                if (ifa.mode != 2'b00) begin
                    m_src = int'(ifa.mode) - 1; m_hold = 0; m_prev_auto = 0;
                end else if (!m_prev_auto) begin
                    m_hold = 0; m_prev_auto = 1;
                end else begin
                    m_hold++;
                    if (m_hold == HR) begin
                        m_hold = 0;
                        found = 0;
                        for (int k = 1; k <= 2; k++)
                            if (!found && ifa.src_valid[(m_src + k) % 3]) begin
                                m_src = (m_src + k) % 3;
                                found = 1;
                            end
                    end
                end
                if (!ifa.freeze) begin
                    m_shadow = (m_src == 0) ? ifa.src0_value :
                               (m_src == 1) ? ifa.src1_value : ifa.src2_value;
                    m_dash   = !ifa.src_valid[m_src];
                end
            end
            m_t++;
        end
    end

    int         c_ph, c_d;
    logic [3:0] c_sel;
    logic [7:0] c_ex, c_ey;

    always @(negedge clock) begin
        if (!reset && check_on) begin
            c_ph  = (m_t / SD) % 8;
            c_d   = c_ph / 2;
            c_sel = (c_ph % 2 == 1) ? ~(4'b0001 << c_d) : 4'b1111;
            check("selectX", 32'(ifa.selectX), 32'(c_sel));
            check("selectY", 32'(ifa.selectY), 32'(c_sel));
            check("tick", 32'(ifa.tick), 32'((m_t % RL) == RL - 1));
            check("active_src", 32'(ifa.active_src), 32'(m_src));
            if (c_ph % 2 == 1) begin
                c_ex = m_dash ? 8'h02 : hex_tab[m_shadow[31 - 4*c_d -: 4]];
                c_ey = m_dash ? 8'h02 : hex_tab[m_shadow[15 - 4*c_d -: 4]];
                check("SEG_X", 32'(ifa.SEG_X), 32'(c_ex));
                check("SEG_Y", 32'(ifa.SEG_Y), 32'(c_ey));
            end
        end
    end

    task automatic wait_t(input int target);
        int n = 0;
        while (m_t != target && n < 2000) begin
            @(negedge clock);
            n++;
        end
        if (m_t != target) begin
            n_checks++;
            n_err++;
            $display("FAIL wait_t: m_t=%0d target=%0d", m_t, target);
        end
    endtask

    int         rnd_src [7] = '{0, 0, 1, 1, 2, 2, 0};
    logic [7:0] rnd_seg [7] = '{8'h60, 8'h60, 8'hF6, 8'hF6, 8'h1A, 8'h1A, 8'h60};
    logic [3:0] selb    [8] = '{4'b1110, 4'b1111, 4'b1101, 4'b1111,
                                4'b1011, 4'b1111, 4'b0111, 4'b1111};

    initial begin
        ifa.src0_value = 32'h1234_5678;
        ifa.src1_value = 32'h9ABC_DEF0;
        ifa.src2_value = 32'hCF1E_2D3C;
        ifa.src_valid  = 3'b111;
        ifa.mode       = 2'b01;
        ifa.freeze     = 1'b0;
        ifb.src0_value = 32'h3000_0000;
        ifb.src1_value = 32'h5000_0000;
        ifb.src2_value = 32'h7000_0000;
        ifb.src_valid  = 3'b111;
        ifb.mode       = 2'b00;
        ifb.freeze     = 1'b0;

        repeat (3) @(negedge clock);
        check("rst_selectX", 32'(ifa.selectX), 32'h0000000F);
        check("rst_SEG_X", 32'(ifa.SEG_X), 32'h0);
        check("rst_SEG_Y", 32'(ifa.SEG_Y), 32'h0);
        check("rst_active", 32'(ifa.active_src), 32'h0);
        check("rst_tick", 32'(ifa.tick), 32'h0);
        reset = 1'b0;
        check_on = 1'b1;

        // Fixed source 0: first round blank value, second round the snapshot
        wait_t(2);  check("r1_segx", 32'(ifa.SEG_X), 32'hFC);
        wait_t(16); check("r2_blank0", 32'(ifa.selectX), 32'hF);
        wait_t(18); check("r2_d0x", 32'(ifa.SEG_X), 32'h60); check("r2_d0y", 32'(ifa.SEG_Y), 32'hB6);
                    check("r2_sel0", 32'(ifa.selectX), 32'hE);
        wait_t(20); check("r2_blank1", 32'(ifa.selectX), 32'hF);
        wait_t(22); check("r2_d1x", 32'(ifa.SEG_X), 32'hDA); check("r2_d1y", 32'(ifa.SEG_Y), 32'hBE);
        wait_t(26); check("r2_d2x", 32'(ifa.SEG_X), 32'hF2); check("r2_d2y", 32'(ifa.SEG_Y), 32'hE0);
        wait_t(30); check("r2_d3x", 32'(ifa.SEG_X), 32'h66); check("r2_d3y", 32'(ifa.SEG_Y), 32'hFE);

        // Auto rotation with all sources valid
        wait_t(35); ifa.mode = 2'b00;
        wait_t(46); check("tick_lo", 32'(ifa.tick), 32'h0);
        wait_t(47); check("tick_hi", 32'(ifa.tick), 32'h1);
        for (int r = 0; r < 7; r++) begin
            wait_t((r + 3) * RL + 2);
            check("rot_src", 32'(ifa.active_src), 32'(rnd_src[r]));
            check("rot_seg", 32'(ifa.SEG_X), 32'(rnd_seg[r]));
        end

        // Source 1 invalid is skipped; then no valid source shows dashes
        wait_t(150); ifa.src_valid = 3'b101;
        wait_t(180); check("skip_r12", 32'(ifa.active_src), 32'h2);
        wait_t(212); check("skip_r14", 32'(ifa.active_src), 32'h0);
        wait_t(226); ifa.src_valid = 3'b000;
        wait_t(242); check("dash_x", 32'(ifa.SEG_X), 32'h02); check("dash_y", 32'(ifa.SEG_Y), 32'h02);

        // Fixed source 2 with freeze
        wait_t(250); ifa.mode = 2'b11; ifa.src_valid = 3'b111; ifa.src2_value = 32'hAAAA_5555;
        wait_t(258); check("frz_r17x", 32'(ifa.SEG_X), 32'hEE); check("frz_r17y", 32'(ifa.SEG_Y), 32'hB6);
        wait_t(260); ifa.freeze = 1'b1; ifa.src2_value = 32'h0;
        wait_t(274); check("frz_r18x", 32'(ifa.SEG_X), 32'hEE);
        wait_t(280); ifa.src2_value = 32'h1111_2222;
        wait_t(290); check("frz_r19x", 32'(ifa.SEG_X), 32'hEE);
        wait_t(300); ifa.freeze = 1'b0;
        wait_t(306); check("unfrz_x", 32'(ifa.SEG_X), 32'h60); check("unfrz_y", 32'(ifa.SEG_Y), 32'hDA);

        // Reset during DRV2
        wait_t(314);
        check("pre_rst_sel", 32'(ifa.selectX), 32'hB);
        reset = 1'b1;
        @(negedge clock);
        check("mid_rst_sel", 32'(ifa.selectX), 32'hF);
        check("mid_rst_segx", 32'(ifa.SEG_X), 32'h0);
        check("mid_rst_segy", 32'(ifa.SEG_Y), 32'h0);
        reset = 1'b0;
        wait_t(1);  check("restart_blank0", 32'(ifa.selectX), 32'hF);
        wait_t(2);  check("restart_drv0", 32'(ifa.selectX), 32'hE);
                    check("restart_seg", 32'(ifa.SEG_X), 32'hFC);
        wait_t(40);

        // SCAN_DIV = 1: phase every cycle; mode change beats hold expiry
        @(negedge clock);
        reset_b = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clock);
            if (k <= 8) check("b_sel", 32'(ifb.selectX), 32'(selb[k - 1]));
            if (k == 1) check("b_r1_seg", 32'(ifb.SEG_X), 32'hFC);
            if (k == 6) check("b_tick_lo", 32'(ifb.tick), 32'h0);
            if (k == 7) check("b_tick_hi", 32'(ifb.tick), 32'h1);
            if (k == 9) check("b_r2_seg", 32'(ifb.SEG_X), 32'hF2);
            if (k == 10) ifb.mode = 2'b11;
            if (k == 17) begin
                check("b_mode_wins", 32'(ifb.active_src), 32'h2);
                check("b_r3_seg", 32'(ifb.SEG_X), 32'hE0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
